// File: rtl/dm9000a_ior.sv
// DM9000A register read sequencer: index write, settle delay, data read.
// Drives the IOWR, usDelay and IORD helper blocks and guards each wait with a watchdog.
module dm9000a_ior #(
  parameter logic [10:0] STD_DELAY      = 11'd20,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
  parameter logic        IO_ADDR        = 1'b0,
  parameter logic        IO_DATA        = 1'b1
) (
  input  logic        iDm9000aClk,
  input  logic        iRst_n,
  input  logic        iRunStart,
  input  logic [15:0] iReg,
  output logic [15:0] oData,
  output logic        oRunEnd,
  output logic        oError,
  output logic        out_to_Dm9000a_IOWR_RunStart,
  output logic        out_to_Dm9000a_IOWR_IndexOrData,
  output logic [15:0] out_to_Dm9000a_IOWR_OutData,
  input  logic        in_from_Dm9000a_IOWR_RunEnd,
  output logic        out_to_Dm9000a_IORD_RunStart,
  output logic        out_to_Dm9000a_IORD_IndexOrData,
  input  logic        in_from_Dm9000a_IORD_RunEnd,
  input  logic [15:0] in_from_Dm9000a_IORD_InData,
  output logic        out_to_Dm9000a_usDelay_RunStart,
  output logic [10:0] out_to_Dm9000a_usDelay_DelayTime,
  input  logic        in_from_Dm9000a_usDelay_RunEnd
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    IDX  = 5'b00010,
    DLY  = 5'b00100,
    RD   = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t      state;
  logic [15:0] regAddr;
  logic [15:0] wdog;
  logic        awaitedEnd;
  logic        timeout;

  // Only the RunEnd belonging to the block currently being driven is honoured.
  always_comb begin
    awaitedEnd = 1'b0;
    case (state)
      IDX:     awaitedEnd = in_from_Dm9000a_IOWR_RunEnd;
      DLY:     awaitedEnd = in_from_Dm9000a_usDelay_RunEnd;
      RD:      awaitedEnd = in_from_Dm9000a_IORD_RunEnd;
      default: awaitedEnd = 1'b0;
    endcase
  end

  // Fires on the TIMEOUT_CYCLES-th clock spent in a waiting state.
  assign timeout = ((wdog + 16'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge iDm9000aClk) begin
    if (!iRst_n) begin
      state   <= IDLE;
      regAddr <= '0;
      wdog    <= '0;
      oData   <= '0;
      oError  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (iRunStart) begin
            regAddr <= iReg;
            oError  <= 1'b0;
            state   <= IDX;
          end
        end
        IDX, DLY, RD: begin
          if (!iRunStart) begin
            wdog  <= '0;
            state <= IDLE;
          end else if (awaitedEnd) begin
            wdog <= '0;
            case (state)
              IDX:     state <= DLY;
              DLY:     state <= RD;
              default: begin
                oData <= in_from_Dm9000a_IORD_InData;
                state <= DONE;
              end
            endcase
          end else if (timeout) begin
            wdog   <= '0;
            oError <= 1'b1;
            state  <= DONE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        DONE: begin
          wdog <= '0;
          if (!iRunStart) state <= IDLE;
        end
        default: begin
          wdog  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign oRunEnd                          = (state == DONE);
  assign out_to_Dm9000a_IOWR_RunStart     = (state == IDX);
  assign out_to_Dm9000a_IOWR_IndexOrData  = (state == IDX) ? IO_ADDR : 1'b0;
  assign out_to_Dm9000a_IOWR_OutData      = (state == IDX) ? regAddr : '0;
  assign out_to_Dm9000a_usDelay_RunStart  = (state == DLY);
  assign out_to_Dm9000a_usDelay_DelayTime = (state == DLY) ? STD_DELAY : '0;
  assign out_to_Dm9000a_IORD_RunStart     = (state == RD);
  assign out_to_Dm9000a_IORD_IndexOrData  = (state == RD) ? IO_DATA : 1'b0;

endmodule
